// File: rtl/typedefs_pkg.sv
// typedefs_pkg: types and constants shared by the fetch front-end and ctrl_unit.
package typedefs_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  // Next-PC selection produced by ctrl_unit; 2'b11 is treated like PC_PLUS4.
  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_TARGET = 2'b01,
    PC_JALR   = 2'b10
  } pc_src_t;

  // A redirect replaces the sequential PC with a branch or JALR target.
  function automatic logic is_redirect(input logic [1:0] src);
    return (src == PC_TARGET) || (src == PC_JALR);
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: small in-order instruction buffer with synchronous flush and
// an occupancy count used by the fetch credit logic.
module instr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer and count update; a flush wins over any push or pop in the same cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
      else if (pop_i && !push_i) count_d = count_q - CNT_W'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the count decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front-end. Issues credit-limited sequential
// requests, buffers returned words in instr_fifo and applies next-PC
// selection on each accepted instruction. Optional macro MISALIGN_CHECK_EN
// adds fetch_misaligned and halts fetch on a redirect to a half-word target.
module fetch_unit
  import typedefs_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [WIDTH-1:0]   imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [WIDTH-1:0]   instr_pc,
  input  logic [1:0]         pc_src,
  input  logic [WIDTH-1:0]   branch_target,
  input  logic [WIDTH-1:0]   jalr_target
`ifdef MISALIGN_CHECK_EN
  ,
  output logic               fetch_misaligned
`endif
);

  localparam int               CW         = $clog2(BUF_DEPTH + 1);
  localparam int               CW1        = CW + 1;
  localparam logic [CW:0]      CREDIT_MAX = CW1'(BUF_DEPTH);
  localparam logic [WIDTH-1:0] STEP       = WIDTH'(PC_STEP);
  localparam logic [WIDTH-1:0] WORD_MASK  = ~(WIDTH'(3));
  localparam logic [WIDTH-1:0] JALR_MASK  = ~(WIDTH'(1));

  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] head_pc_q, head_pc_d;
  logic [CW-1:0]    outstanding_q, outstanding_d;
  logic [CW-1:0]    discard_q, discard_d;
  logic             run_q;
  logic             halted_q, halted_d;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      credit_used;
  logic             fifo_empty;
  logic             grant, accept, redirect, misalign_hit;
  logic             push, pop, flush;
  logic [WIDTH-1:0] raw_target;

  assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req    = run_q && !halted_q && (credit_used < CREDIT_MAX);
  assign imem_addr   = fetch_pc_q;
  assign grant       = imem_req && imem_gnt;
  assign instr_valid = !fifo_empty && !halted_q;
  assign instr_pc    = head_pc_q;
  assign accept      = instr_valid && instr_ready;
  assign redirect    = accept && is_redirect(pc_src);
  assign raw_target  = (pc_src == PC_JALR) ? (jalr_target & JALR_MASK) : branch_target;

`ifdef MISALIGN_CHECK_EN
  logic misaligned_q;
  assign misalign_hit     = raw_target[1];
  assign fetch_misaligned = misaligned_q;
`else
  assign misalign_hit = 1'b0;
`endif

  // Next-state: grant/response bookkeeping first, then accept overrides for redirects.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    head_pc_d     = head_pc_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);
    discard_d     = discard_q;
    halted_d      = halted_q;
    push          = 1'b0;
    pop           = 1'b0;
    flush         = 1'b0;
    if (grant) fetch_pc_d = fetch_pc_q + STEP;
    if (imem_rvalid) begin
      if (discard_q != '0) discard_d = discard_q - CW'(1);
      else                 push      = 1'b1;
    end
    if (accept) begin
      if (redirect) begin
        flush      = 1'b1;
        push       = 1'b0;
        head_pc_d  = raw_target & WORD_MASK;
        fetch_pc_d = raw_target & WORD_MASK;
        discard_d  = outstanding_d;
        if (misalign_hit) halted_d = 1'b1;
      end else begin
        pop       = 1'b1;
        head_pc_d = head_pc_q + STEP;
      end
    end
  end

  // State registers; run_q holds off the first request until one cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      head_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      run_q         <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      head_pc_q     <= head_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      run_q         <= 1'b1;
      halted_q      <= halted_d;
    end
  end

`ifdef MISALIGN_CHECK_EN
  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       misaligned_q <= 1'b0;
    else if (redirect && misalign_hit) misaligned_q <= 1'b1;
  end
`endif

  instr_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (imem_rdata),
    .pop_i   (pop),
    .flush_i (flush),
    .head_o  (instr),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule
